// File: rtl/puzzle_pkg.sv
// rtl/puzzle_pkg.sv - shared widths and FSM state encoding for the toggle-puzzle game sequencer
package puzzle_pkg;
   localparam int NUM_LEVELS_MAX = 8;
   localparam int LEVEL_W        = 3;
   localparam int BTN_W          = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CLEAR    = 3'd1,
      ST_ARM      = 3'd2,
      ST_PLAY     = 3'd3,
      ST_WIN_HOLD = 3'd4,
      ST_DONE     = 3'd5,
      ST_FAIL     = 3'd6
   } state_t;
endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, stability counter and single-cycle rising-edge pulse
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic pulse
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1;
   logic             sync2;
   logic             stable;
   logic [CNT_W-1:0] cnt;

   // Any sample that matches the accepted level restarts the count, so bounces never accumulate.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
         pulse  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         pulse <= 1'b0;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
            stable <= sync2;
            cnt    <= '0;
            pulse  <= sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/puzzle_game_ctrl.sv
// rtl/puzzle_game_ctrl.sv - game sequencer for the 8x8 toggle puzzle; PUZZLE_MOVE_LIMIT_EN adds the FAIL state
module puzzle_game_ctrl
   import puzzle_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int WIN_HOLD_CYCLES = 50000000,
   parameter int NUM_LEVELS      = 5,
   parameter int MOVE_LIMIT      = 31
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [BTN_W-1:0]   btn_raw,
   input  logic               level_done,
   output logic [BTN_W-1:0]   btn_pulse,
   output logic               matrix_clear,
   output logic [LEVEL_W-1:0] nivel,
   output logic [7:0]         moves,
   output logic               game_won,
   output logic               game_lost,
   output logic [2:0]         db_estado
);
   localparam int HOLD_W = (WIN_HOLD_CYCLES > 1) ? $clog2(WIN_HOLD_CYCLES) : 1;

   if (NUM_LEVELS < 1 || NUM_LEVELS > NUM_LEVELS_MAX || MOVE_LIMIT < 1 || MOVE_LIMIT > 255) begin : g_bad_cfg
      $error("puzzle_game_ctrl: NUM_LEVELS must be 1..8 and MOVE_LIMIT 1..255");
   end

   logic [BTN_W:0] raw_all;
   logic [BTN_W:0] pulse_all;
   logic           start_pulse;
   logic           move;

   assign raw_all     = {start, btn_raw};
   assign start_pulse = pulse_all[BTN_W];

   for (genvar i = 0; i <= BTN_W; i++) begin : g_db
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk  (clk),
         .reset(reset),
         .raw  (raw_all[i]),
         .pulse(pulse_all[i])
      );
   end

   state_t             state;
   state_t             state_n;
   logic [LEVEL_W-1:0] nivel_n;
   logic [7:0]         moves_n;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [HOLD_W-1:0]  hold_n;
   logic               arm_cnt;
   logic               arm_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         nivel    <= '0;
         moves    <= '0;
         hold_cnt <= '0;
         arm_cnt  <= 1'b0;
      end else begin
         state    <= state_n;
         nivel    <= nivel_n;
         moves    <= moves_n;
         hold_cnt <= hold_n;
         arm_cnt  <= arm_n;
      end
   end

   always_comb begin
      state_n      = state;
      nivel_n      = nivel;
      moves_n      = moves;
      hold_n       = hold_cnt;
      arm_n        = arm_cnt;
      btn_pulse    = (state == ST_PLAY) ? pulse_all[BTN_W-1:0] : '0;
      move         = |btn_pulse;
      matrix_clear = (state == ST_CLEAR);
      game_won     = (state == ST_DONE);
`ifdef PUZZLE_MOVE_LIMIT_EN
      game_lost    = (state == ST_FAIL);
`else
      game_lost    = 1'b0;
`endif
      db_estado    = state;

      if (move && moves != 8'hFF) begin
         moves_n = moves + 8'd1;
      end

      case (state)
         ST_IDLE: begin
            if (start_pulse) begin
               state_n = ST_CLEAR;
               nivel_n = '0;
            end
         end
         ST_CLEAR: begin
            moves_n = '0;
            arm_n   = 1'b0;
            state_n = ST_ARM;
         end
         // The matrix flag lags its clear by a register stage; ignore it until it has settled.
         ST_ARM: begin
            if (arm_cnt) begin
               state_n = ST_PLAY;
            end else begin
               arm_n = 1'b1;
            end
         end
         ST_PLAY: begin
            if (level_done) begin
               state_n = ST_WIN_HOLD;
               hold_n  = HOLD_W'(WIN_HOLD_CYCLES - 1);
`ifdef PUZZLE_MOVE_LIMIT_EN
            end else if (move && moves_n == 8'(MOVE_LIMIT)) begin
               state_n = ST_FAIL;
`endif
            end else if (start_pulse) begin
               state_n = ST_CLEAR;
            end
         end
         ST_WIN_HOLD: begin
            if (hold_cnt == '0) begin
               if (nivel == LEVEL_W'(NUM_LEVELS - 1)) begin
                  state_n = ST_DONE;
               end else begin
                  nivel_n = nivel + LEVEL_W'(1);
                  state_n = ST_CLEAR;
               end
            end else begin
               hold_n = hold_cnt - HOLD_W'(1);
            end
         end
         ST_DONE: begin
            if (start_pulse) begin
               state_n = ST_CLEAR;
               nivel_n = '0;
            end
         end
`ifdef PUZZLE_MOVE_LIMIT_EN
         ST_FAIL: begin
            if (start_pulse) begin
               state_n = ST_CLEAR;
            end
         end
`endif
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end
endmodule
